// File: rtl/xcache_param_pkg.sv
// Shared XCACHE bus constants and request payload type.
package xcache_param_pkg;

  localparam int unsigned XCACHE_ADDR_WIDTH = 32;
  localparam int unsigned XCACHE_DATA_WIDTH = 32;
  localparam int unsigned XCACHE_PART_WIDTH = 8;
  localparam int unsigned XCACHE_WE_WIDTH   = 4;
  localparam int unsigned XCACHE_MAX_RD_OUT = 4;

  typedef struct packed {
    logic [XCACHE_PART_WIDTH-1:0] part;
    logic                         re;
    logic [XCACHE_WE_WIDTH-1:0]   we;
    logic [XCACHE_ADDR_WIDTH-1:0] ad;
    logic [XCACHE_DATA_WIDTH-1:0] di;
  } xcache_req_t;

endpackage

// File: rtl/xcache_req_fifo2.sv
// Two-entry in-order request FIFO; entry0 is always the head and keeps
// its last value once drained so downstream address/data lines stay quiet.
module xcache_req_fifo2
  import xcache_param_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  xcache_req_t din,
  output logic [1:0]  cnt,
  output xcache_req_t head
);

  xcache_req_t entry0;
  xcache_req_t entry1;

  assign head = entry0;

  // Storage and occupancy update; pop shifts entry1 forward only when it holds data.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry0 <= '0;
      entry1 <= '0;
      cnt    <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) entry0 <= din;
          else             entry1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          if (cnt == 2'd2) entry0 <= entry1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd2) begin
            entry0 <= entry1;
            entry1 <= din;
          end else begin
            entry0 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/xcache_req_slice.sv
// Registered request slice between the XCACHE arbiter and the XCACHE port.
// Caps outstanding reads so the arbiter's return-index queue cannot overflow.
// Build option XCACHE_REQ_SLICE_RSP_REG_EN registers the read response path.
module xcache_req_slice
  import xcache_param_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_RD_OUT = XCACHE_MAX_RD_OUT,
  parameter int unsigned CNT_W      = $clog2(MAX_RD_OUT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            up_part,
  input  logic                  up_re,
  input  logic [3:0]            up_we,
  input  logic [ADDR_WIDTH-1:0] up_ad,
  input  logic [DATA_WIDTH-1:0] up_di,
  output logic                  up_rdy,
  output logic [DATA_WIDTH-1:0] up_do,
  output logic                  up_do_vld,
  input  logic                  mem_rdy,
  output logic [7:0]            mem_part,
  output logic                  mem_re,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_ad,
  output logic [DATA_WIDTH-1:0] mem_di,
  input  logic [DATA_WIDTH-1:0] mem_do,
  input  logic                  mem_do_vld,
  output logic                  rsp_err
);

  logic [1:0]       fifo_cnt;
  logic             fifo_nempty;
  xcache_req_t      req_in;
  xcache_req_t      head;
  logic [CNT_W-1:0] rd_cnt;
  logic             up_req;
  logic             up_acc;
  logic             dn_acc;
  logic             rd_inc;
  logic             rd_dec;

  // Accept decisions; up_rdy depends only on registered occupancy and credit.
  always_comb begin
    up_rdy      = (fifo_cnt < 2'd2) && (rd_cnt < CNT_W'(MAX_RD_OUT));
    up_req      = up_re | (|up_we);
    up_acc      = up_req & up_rdy;
    fifo_nempty = (fifo_cnt != 2'd0);
    dn_acc      = fifo_nempty & mem_rdy;
    rd_inc      = up_acc & up_re;
    rd_dec      = up_do_vld & (rd_cnt != '0);
    req_in.part = up_part;
    req_in.re   = up_re;
    req_in.we   = up_we;
    req_in.ad   = XCACHE_ADDR_WIDTH'(up_ad);
    req_in.di   = XCACHE_DATA_WIDTH'(up_di);
  end

  xcache_req_fifo2 u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (up_acc),
    .pop  (dn_acc),
    .din  (req_in),
    .cnt  (fifo_cnt),
    .head (head)
  );

  assign mem_part = head.part;
  assign mem_re   = head.re & fifo_nempty;
  assign mem_we   = head.we & {4{fifo_nempty}};
  assign mem_ad   = ADDR_WIDTH'(head.ad);
  assign mem_di   = DATA_WIDTH'(head.di);

`ifdef XCACHE_REQ_SLICE_RSP_REG_EN
  logic                  rsp_vld_q;
  logic [DATA_WIDTH-1:0] rsp_do_q;

  // One-cycle response register; data holds between valid beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld_q <= 1'b0;
      rsp_do_q  <= '0;
    end else begin
      rsp_vld_q <= mem_do_vld;
      if (mem_do_vld) rsp_do_q <= mem_do;
    end
  end

  assign up_do_vld = rsp_vld_q;
  assign up_do     = rsp_do_q;
`else
  assign up_do_vld = mem_do_vld;
  assign up_do     = mem_do;
`endif

  // Outstanding-read credit counter, saturating at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt <= '0;
    end else begin
      unique case ({rd_inc, rd_dec})
        2'b10:   rd_cnt <= rd_cnt + CNT_W'(1);
        2'b01:   rd_cnt <= rd_cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Sticky flag for a response with no read outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_err <= 1'b0;
    end else if (up_do_vld && (rd_cnt == '0)) begin
      rsp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_xcache_req_slice.sv
// Self-checking bench for xcache_req_slice: queue-based reference model
// compared every cycle, plus directed checks with literal expectations.
module tb_xcache_req_slice;

  localparam int MAX = 4;
`ifdef XCACHE_REQ_SLICE_RSP_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic        clk;
  logic        rst;
  logic [7:0]  up_part;
  logic        up_re;
  logic [3:0]  up_we;
  logic [31:0] up_ad;
  logic [31:0] up_di;
  logic        up_rdy;
  logic [31:0] up_do;
  logic        up_do_vld;
  logic        mem_rdy;
  logic [7:0]  mem_part;
  logic        mem_re;
  logic [3:0]  mem_we;
  logic [31:0] mem_ad;
  logic [31:0] mem_di;
  logic [31:0] mem_do;
  logic        mem_do_vld;
  logic        rsp_err;

  xcache_req_slice dut (
    .clk        (clk),
    .rst        (rst),
    .up_part    (up_part),
    .up_re      (up_re),
    .up_we      (up_we),
    .up_ad      (up_ad),
    .up_di      (up_di),
    .up_rdy     (up_rdy),
    .up_do      (up_do),
    .up_do_vld  (up_do_vld),
    .mem_rdy    (mem_rdy),
    .mem_part   (mem_part),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_ad     (mem_ad),
    .mem_di     (mem_di),
    .mem_do     (mem_do),
    .mem_do_vld (mem_do_vld),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: a queue of accepted requests, a read count and a sticky error bit.
  typedef struct {
    logic [7:0]  part;
    logic        re;
    logic [3:0]  we;
    logic [31:0] ad;
    logic [31:0] di;
  } req_s;

  req_s        mq[$];
  req_s        mlast;
  int          mrd  = 0;
  bit          merr = 0;
  bit          mvld = 0;
  logic [31:0] mdo  = '0;
  bit          live = 0;

  always @(posedge clk) begin
    bit   vld_now;
    bit   rdy;
    bit   acc;
    bit   dec;
    req_s r;
    vld_now = (LAT == 1) ? mvld : mem_do_vld;
    if (rst) begin
      mq.delete();
      mlast = '{part: 8'h0, re: 1'b0, we: 4'h0, ad: 32'h0, di: 32'h0};
      mrd   = 0;
      merr  = 0;
      mvld  = 0;
      mdo   = '0;
      live  = 1;
    end else begin
      rdy = (mq.size() < 2) && (mrd < MAX);
      acc = (up_re || (up_we != 4'h0)) && rdy;
      if (mq.size() > 0 && mem_rdy) begin
        mlast = mq[0];
        mq.pop_front();
      end
      if (acc) begin
        r = '{part: up_part, re: up_re, we: up_we, ad: up_ad, di: up_di};
        mq.push_back(r);
      end
      if (vld_now && mrd == 0) merr = 1;
      dec = vld_now && (mrd > 0);
      if (acc && up_re) mrd++;
      if (dec) mrd--;
      mvld = mem_do_vld;
      if (mem_do_vld) mdo = mem_do;
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    req_s h;
    if (live) begin
      if (mq.size() > 0) h = mq[0];
      else begin
        h = mlast;
        h.re = 1'b0;
        h.we = 4'h0;
      end
      chk("m_up_rdy",    64'(up_rdy),    64'((mq.size() < 2) && (mrd < MAX)));
      chk("m_mem_re",    64'(mem_re),    64'(h.re));
      chk("m_mem_we",    64'(mem_we),    64'(h.we));
      chk("m_mem_part",  64'(mem_part),  64'(h.part));
      chk("m_mem_ad",    64'(mem_ad),    64'(h.ad));
      chk("m_mem_di",    64'(mem_di),    64'(h.di));
      chk("m_up_do_vld", 64'(up_do_vld), 64'((LAT == 1) ? mvld : mem_do_vld));
      chk("m_up_do",     64'(up_do),     64'((LAT == 1) ? mdo : mem_do));
      chk("m_rsp_err",   64'(rsp_err),   64'(merr));
      chk("m_rd_cnt",    64'(dut.rd_cnt), 64'(mrd));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    up_re = 1'b0;
    up_we = 4'h0;
  endtask

  task automatic resp(input logic [31:0] d);
    mem_do     = d;
    mem_do_vld = 1'b1;
    tick();
    mem_do_vld = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; up_part = 8'h0; up_re = 1'b0; up_we = 4'h0; up_ad = '0; up_di = '0;
    mem_rdy = 1'b0; mem_do = '0; mem_do_vld = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_up_rdy", 64'(up_rdy), 64'd1);
    chk("rst_mem_re", 64'(mem_re), 64'd0);
    chk("rst_mem_ad", 64'(mem_ad), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_up_do_vld", 64'(up_do_vld), 64'd0);

    // Single write
    mem_rdy = 1'b1; up_part = 8'h12; up_we = 4'hF; up_ad = 32'h100; up_di = 32'hDEAD_BEEF;
    tick();
    idle();
    chk("wr_mem_we", 64'(mem_we), 64'hF);
    chk("wr_mem_ad", 64'(mem_ad), 64'h100);
    chk("wr_mem_di", 64'(mem_di), 64'hDEAD_BEEF);
    chk("wr_mem_part", 64'(mem_part), 64'h12);
    tick();
    chk("wr_once_we", 64'(mem_we), 64'h0);
    chk("wr_hold_ad", 64'(mem_ad), 64'h100);
    chk("wr_rd_cnt", 64'(dut.rd_cnt), 64'd0);

    // Backpressure with three writes
    mem_rdy = 1'b0; up_we = 4'h1; up_ad = 32'h200; up_di = 32'hA0;
    tick();
    up_ad = 32'h204; up_di = 32'hA4;
    tick();
    chk("bp_rdy_low", 64'(up_rdy), 64'd0);
    up_ad = 32'h208; up_di = 32'hA8;
    tick();
    chk("bp_head_stable", 64'(mem_ad), 64'h200);
    mem_rdy = 1'b1;
    tick();
    chk("bp_drain1", 64'(mem_ad), 64'h204);
    chk("bp_rdy_back", 64'(up_rdy), 64'd1);
    tick();
    idle();
    chk("bp_drain2", 64'(mem_ad), 64'h208);
    tick();
    chk("bp_empty_we", 64'(mem_we), 64'h0);

    // Read cap
    up_re = 1'b1;
    for (int i = 0; i < 5; i++) begin
      up_ad = 32'h300 + 32'(4 * i);
      tick();
    end
    chk("cap_rd_cnt", 64'(dut.rd_cnt), 64'd4);
    chk("cap_rdy_low", 64'(up_rdy), 64'd0);
    resp(32'h1234);
    chk("cap_up_do", 64'(up_do), 64'h1234);
    repeat (1 + LAT) tick();
    idle();
    tick();
    chk("cap_fifth_acc", 64'(dut.rd_cnt), 64'd4);

    // Drain to two outstanding, then overlap accept and response
    resp(32'h1);
    resp(32'h2);
    repeat (LAT) tick();
    chk("sim_pre", 64'(dut.rd_cnt), 64'd2);
    mem_do = 32'h3; mem_do_vld = 1'b1;
    repeat (LAT) begin
      tick();
      mem_do_vld = 1'b0;
    end
    up_re = 1'b1; up_ad = 32'h400;
    tick();
    idle(); mem_do_vld = 1'b0;
    chk("sim_rd_cnt", 64'(dut.rd_cnt), 64'd2);
    resp(32'h4);
    resp(32'h5);
    repeat (LAT + 1) tick();
    chk("drain_rd_cnt", 64'(dut.rd_cnt), 64'd0);
    chk("drain_no_err", 64'(rsp_err), 64'd0);

    // Spurious response
    resp(32'hBAD);
    repeat (LAT) tick();
    chk("spur_err", 64'(rsp_err), 64'd1);
    up_we = 4'h3; up_ad = 32'h500;
    tick();
    idle();
    tick(); tick();
    chk("spur_sticky", 64'(rsp_err), 64'd1);

    // Reset mid-traffic
    mem_rdy = 1'b1; up_re = 1'b1; up_ad = 32'h600;
    tick();
    up_ad = 32'h604;
    tick();
    mem_rdy = 1'b0; up_ad = 32'h608;
    tick();
    idle();
    chk("mid_rd_cnt", 64'(dut.rd_cnt), 64'd3);
    chk("mid_rdy_low", 64'(up_rdy), 64'd0);
    chk("mid_mem_re", 64'(mem_re), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_mem_re", 64'(mem_re), 64'd0);
    chk("rst2_mem_we", 64'(mem_we), 64'd0);
    chk("rst2_rd_cnt", 64'(dut.rd_cnt), 64'd0);
    chk("rst2_up_rdy", 64'(up_rdy), 64'd1);
    chk("rst2_rsp_err", 64'(rsp_err), 64'd0);
    mem_rdy = 1'b1;
    resp(32'h55);
    repeat (LAT) tick();
    chk("late_rsp_do", 64'(up_do), 64'h55);
    chk("late_rsp_err", 64'(rsp_err), 64'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
